rv_bus_sequencer: RTL and testbench
===================================

Name: rv_bus_sequencer

Overview:
- Generalised external-bus cycle engine between the RV4028 core's 32-bit load/store port and the board bus.
- Splits each 32-bit access into BUS_WIDTH-wide beats and skips beats whose byte mask is empty.
- Generates half-cycle (DDR) mreq_n/wr_n phase pairs for pad-level DDR output cells, inserts programmable minimum wait states, and honours wait_n.

Parameters:
BUS_WIDTH, 16, external data width in bits; legal values 8, 16, 32; NBEATS = 32/BUS_WIDTH, BB = BUS_WIDTH/8.
ADDR_WIDTH, 32, external address width.
MIN_WAIT, 0, Tw cycles always inserted per beat before wait_n is honoured (0..15).
IO_ADDR_BIT, 31, address bit that selects I/O space.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  core access request.
req_ready  out  1  sequencer idle; request is accepted on clk edge when req_valid&req_ready.
req_addr  in  32  byte address; bits [1:0] ignored.
req_we  in  1  1=write, 0=read.
req_mask  in  4  byte enables for lanes 3..0.
req_wdata  in  32  write data.
rsp_valid  out  1  one-cycle completion pulse, reads and writes.
rsp_rdata  out  32  read data, valid with rsp_valid; unenabled bytes are 0.
addr  out  ADDR_WIDTH  beat address.
wr_n  out  2  write strobe phases; [0]=first half-cycle, [1]=second half-cycle.
mreq_n  out  2  memory request phases, same encoding.
rd_n  out  1  read strobe.
msk_n  out  BB  active-low lane enables.
iorq_n  out  1  I/O space indicator.
wait_n  in  1  synchronous; low extends Tw.
data_in  in  BUS_WIDTH  bus read data.
data_out  out  BUS_WIDTH  bus write data.
data_oe  out  1  data output enable.

Behaviour:
- States: IDLE, T1, T2 (includes Tw), T3.
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; addr=0; wr_n=2'b11; mreq_n=2'b11; rd_n=1; msk_n=all 1; iorq_n=1; data_oe=0; data_out=0; wait counter 0.
  - Reset mid-beat aborts the access. No rsp_valid is produced and no strobe glitches low.
- IDLE:
  - req_ready=1.
  - On accept, latch addr/we/mask/wdata.
  - Beat k covers mask bits [k*BB+BB-1 : k*BB]. Pick the lowest k with a nonzero slice and go to T1.
  - If mask==0: no bus cycle; rsp_valid=1 the next cycle, rsp_rdata=0, stay IDLE.
- Per-beat outputs, held T1..T3:
  - addr = {req_addr[ADDR_WIDTH-1:2],2'b00} + k*BB.
  - msk_n = ~slice.
  - iorq_n = ~addr[IO_ADDR_BIT].
  - Writes: data_out = wdata[k*BUS_WIDTH +: BUS_WIDTH], data_oe=1.
- T1: mreq_n=2'b01 (asserts mid-cycle); wr_n=2'b11; rd_n=1. Load wait counter = MIN_WAIT. Next state T2.
- T2:
  - mreq_n=2'b00.
  - Writes: wr_n=2'b00. Reads: rd_n=0.
  - If counter≠0: decrement and stay.
  - Else if wait_n==0: stay.
  - Else: reads capture data_in into rsp_rdata lanes of beat k, masked bytes zeroed; go to T3.
- T3:
  - mreq_n=2'b10; writes wr_n=2'b10 (release mid-cycle); reads rd_n=0.
  - If a later beat has a nonzero slice: go to T1 for that beat.
  - Else: rsp_valid=1 in this cycle, then IDLE.
- Outside T1..T3: strobes inactive, data_oe=0, and addr holds its last value.
- req_ready=0 from accept until the cycle after the final T3.
- Latency with BUS_WIDTH=16, MIN_WAIT=0, no wait_n, full mask: accept at edge 0; T1,T2,T3,T1,T2,T3 in cycles 1-6; rsp_valid in cycle 6; req_ready=1 in cycle 7.
- Each beat adds MIN_WAIT plus the number of wait_n-low cycles sampled after the counter expires.
- A new request can be accepted only in IDLE; back-to-back accesses cost at least one IDLE cycle.

Test Plan:
- Reset values: assert rst mid-T2 of a write → next sample shows mreq_n=2'b11, wr_n=2'b11, data_oe=0, req_ready=1; no rsp_valid ever appears.
- BUS_WIDTH=16, MIN_WAIT=0, read addr 0x00001002, mask 4'hF, data_in 0xBEEF then 0xDEAD → addr 0x1000 then 0x1002; msk_n=2'b00; rsp_rdata=0xDEADBEEF in cycle 6; mreq_n sequence 01,00,10 per beat.
- Write mask 4'b1100, wdata 0x12345678, BUS_WIDTH=16 → single beat at base+2; data_out=0x1234, msk_n=2'b00; rsp_valid at cycle 3; wr_n 11,00,10.
- MIN_WAIT=2 with wait_n low for 3 cycles after expiry, single beat → T2 lasts 6 cycles; data_in captured only at the final T2 edge.
- BUS_WIDTH=8, read mask 4'b0101 at addr 0x80000000 → beats at 0x80000000 and 0x80000002 only; iorq_n=0; rsp_rdata bytes 1 and 3 equal 0.
- mask 4'h0 → no strobes; rsp_valid one cycle after accept; rsp_rdata=0.

Source files
------------

// File: rtl/rv_bus_sequencer.sv
// External-bus cycle engine: splits a 32-bit core access into BUS_WIDTH beats,
// drives DDR mreq_n/wr_n phase pairs, and stretches T2 for MIN_WAIT and wait_n.
module rv_bus_sequencer #(
  parameter int BUS_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int MIN_WAIT    = 0,
  parameter int IO_ADDR_BIT = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_we,
  input  logic [3:0]              req_mask,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [1:0]              wr_n,
  output logic [1:0]              mreq_n,
  output logic                    rd_n,
  output logic [BUS_WIDTH/8-1:0]  msk_n,
  output logic                    iorq_n,
  input  logic                    wait_n,
  input  logic [BUS_WIDTH-1:0]    data_in,
  output logic [BUS_WIDTH-1:0]    data_out,
  output logic                    data_oe
);
  localparam int NBEATS = 32 / BUS_WIDTH;
  localparam int BB     = BUS_WIDTH / 8;
  localparam int KW     = 2;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] base_q;
  logic                  we_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q;
  logic [KW-1:0]         beat_q;
  logic [3:0]            wcnt;

  // {found, index} of the lowest beat at or above 'from' with a nonzero mask slice
  function automatic logic [KW:0] find_beat(input logic [3:0] m, input int from);
    logic [KW:0] r;
    r = '0;
    for (int k = NBEATS-1; k >= 0; k--)
      if (k >= from && m[k*BB +: BB] != '0) r = {1'b1, KW'(k)};
    return r;
  endfunction

  logic [KW:0]           first_b, next_b;
  logic [ADDR_WIDTH-1:0] req_base, ld_base, ld_addr;
  logic [3:0]            ld_mask;
  logic [31:0]           ld_wdata;
  logic                  ld_we;
  logic [KW-1:0]         ld_k;
  logic [BB-1:0]         ld_slice;
  logic [BUS_WIDTH-1:0]  ld_dout;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_base = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign first_b  = find_beat(req_mask, 0);
  assign next_b   = find_beat(mask_q, int'(beat_q) + 1);

  // Beat to load next: the first beat of a new request in IDLE, else the following beat
  always_comb begin
    if (state == IDLE) begin
      ld_base  = req_base;
      ld_mask  = req_mask;
      ld_wdata = req_wdata;
      ld_we    = req_we;
      ld_k     = first_b[KW-1:0];
    end else begin
      ld_base  = base_q;
      ld_mask  = mask_q;
      ld_wdata = wdata_q;
      ld_we    = we_q;
      ld_k     = next_b[KW-1:0];
    end
    ld_addr  = ld_base + ADDR_WIDTH'(int'(ld_k) * BB);
    ld_slice = ld_mask[int'(ld_k)*BB +: BB];
    ld_dout  = ld_wdata[int'(ld_k)*BUS_WIDTH +: BUS_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr      <= '0;
      wr_n      <= 2'b11;
      mreq_n    <= 2'b11;
      rd_n      <= 1'b1;
      msk_n     <= '1;
      iorq_n    <= 1'b1;
      data_oe   <= 1'b0;
      data_out  <= '0;
      wcnt      <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      mask_q    <= '0;
      wdata_q   <= '0;
      beat_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            base_q    <= req_base;
            we_q      <= req_we;
            mask_q    <= req_mask;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            if (first_b[KW]) begin
              state     <= T1;
              req_ready <= 1'b0;
              beat_q    <= ld_k;
              addr      <= ld_addr;
              msk_n     <= ~ld_slice;
              iorq_n    <= ~ld_addr[IO_ADDR_BIT];
              data_oe   <= ld_we;
              if (ld_we) data_out <= ld_dout;
              mreq_n    <= 2'b01;
            end else begin
              rsp_valid <= 1'b1;
            end
          end
        end
        T1: begin
          state  <= T2;
          mreq_n <= 2'b00;
          wr_n   <= we_q ? 2'b00 : 2'b11;
          rd_n   <= we_q;
          wcnt   <= 4'(MIN_WAIT);
        end
        T2: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 4'd1;
          end else if (wait_n) begin
            if (!we_q)
              for (int b = 0; b < BB; b++)
                if (mask_q[int'(beat_q)*BB + b])
                  rsp_rdata[int'(beat_q)*BUS_WIDTH + b*8 +: 8] <= data_in[b*8 +: 8];
            state  <= T3;
            mreq_n <= 2'b10;
            wr_n   <= we_q ? 2'b10 : 2'b11;
            if (!next_b[KW]) rsp_valid <= 1'b1;
          end
        end
        T3: begin
          if (next_b[KW]) begin
            state   <= T1;
            beat_q  <= ld_k;
            addr    <= ld_addr;
            msk_n   <= ~ld_slice;
            iorq_n  <= ~ld_addr[IO_ADDR_BIT];
            data_oe <= ld_we;
            if (ld_we) data_out <= ld_dout;
            mreq_n  <= 2'b01;
            wr_n    <= 2'b11;
            rd_n    <= 1'b1;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mreq_n    <= 2'b11;
            wr_n      <= 2'b11;
            rd_n      <= 1'b1;
            msk_n     <= '1;
            iorq_n    <= 1'b1;
            data_oe   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_bus_sequencer.sv
// Bench for rv_bus_sequencer: three configurations (16-bit, 16-bit with waits, 8-bit),
// completions checked against a per-instance scoreboard of expected rsp cycle/data.
module tb_rv_bus_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_we = 1'b0, wait_n = 1'b1;
  logic [3:0]  req_mask = '0;
  logic        v16 = 1'b0, vw = 1'b0, v8 = 1'b0;

  logic        r16_ready, r16_valid, rd16, io16, oe16;
  logic [31:0] r16_rdata, a16;
  logic [1:0]  wr16, mq16, mk16;
  logic [15:0] din16, dout16;

  logic        rw_ready, rw_valid, rdw, iow, oew;
  logic [31:0] rw_rdata, aw;
  logic [1:0]  wrw, mqw, mkw;
  logic [15:0] dinw = 16'hAAAA, doutw;

  logic        r8_ready, r8_valid, rd8, io8, oe8, mk8;
  logic [31:0] r8_rdata, a8;
  logic [1:0]  wr8, mq8;
  logic [7:0]  din8, dout8;

  // simple bus memories: data is a function of the beat address
  assign din16 = (a16 == 32'h1000) ? 16'hBEEF : (a16 == 32'h1002) ? 16'hDEAD : a16[15:0];
  assign din8  = 8'hC0 | {4'h0, a8[3:0]};

  rv_bus_sequencer #(.BUS_WIDTH(16), .MIN_WAIT(0)) d16 (
    .clk(clk), .rst(rst), .req_valid(v16), .req_ready(r16_ready), .req_addr(req_addr),
    .req_we(req_we), .req_mask(req_mask), .req_wdata(req_wdata), .rsp_valid(r16_valid),
    .rsp_rdata(r16_rdata), .addr(a16), .wr_n(wr16), .mreq_n(mq16), .rd_n(rd16), .msk_n(mk16),
    .iorq_n(io16), .wait_n(wait_n), .data_in(din16), .data_out(dout16), .data_oe(oe16));

  rv_bus_sequencer #(.BUS_WIDTH(16), .MIN_WAIT(2)) dw (
    .clk(clk), .rst(rst), .req_valid(vw), .req_ready(rw_ready), .req_addr(req_addr),
    .req_we(req_we), .req_mask(req_mask), .req_wdata(req_wdata), .rsp_valid(rw_valid),
    .rsp_rdata(rw_rdata), .addr(aw), .wr_n(wrw), .mreq_n(mqw), .rd_n(rdw), .msk_n(mkw),
    .iorq_n(iow), .wait_n(wait_n), .data_in(dinw), .data_out(doutw), .data_oe(oew));

  rv_bus_sequencer #(.BUS_WIDTH(8), .MIN_WAIT(0)) d8 (
    .clk(clk), .rst(rst), .req_valid(v8), .req_ready(r8_ready), .req_addr(req_addr),
    .req_we(req_we), .req_mask(req_mask), .req_wdata(req_wdata), .rsp_valid(r8_valid),
    .rsp_rdata(r8_rdata), .addr(a8), .wr_n(wr8), .mreq_n(mq8), .rd_n(rd8), .msk_n(mk8),
    .iorq_n(io8), .wait_n(wait_n), .data_in(din8), .data_out(dout8), .data_oe(oe8));

  typedef struct {
    logic [31:0] rdata;
    logic        is_read;
    int          cyc;
  } exp_t;

  exp_t sb16[$], sbw[$], sb8[$];
  int errors = 0, checks = 0;

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({r16_ready, r16_valid, wr16, mq16, rd16, mk16, io16, oe16} !== 11'b1_0_11_11_1_11_1_0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required %b",
               {r16_ready, r16_valid, wr16, mq16, rd16, mk16, io16, oe16}, 11'b1_0_11_11_1_11_1_0);
    end
    checks++;
    if (r16_rdata !== 32'h0 || a16 !== 32'h0 || dout16 !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h addr=%h dout=%h required all 0", r16_rdata, a16, dout16);
    end
    checks++;
    if (r8_ready !== 1'b1 || mk8 !== 1'b1 || rw_ready !== 1'b1 || mqw !== 2'b11) begin
      errors++;
      $display("FAIL reset_others got r8_ready=%b mk8=%b rw_ready=%b mqw=%b required 1 1 1 11",
               r8_ready, mk8, rw_ready, mqw);
    end
    rst = 1'b0;
    req_addr = 32'h2000; req_we = 1'b1; req_mask = 4'hF; req_wdata = 32'hCAFEF00D; v16 = 1'b1;
    @(negedge clk); v16 = 1'b0;
    @(negedge clk);
    checks++;
    if (mq16 !== 2'b00 || wr16 !== 2'b00 || oe16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_t2 got mreq_n=%b wr_n=%b oe=%b required 00 00 1", mq16, wr16, oe16);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mq16 !== 2'b11 || wr16 !== 2'b11 || oe16 !== 1'b0 || r16_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midbeat got mreq_n=%b wr_n=%b oe=%b ready=%b required 11 11 0 1",
               mq16, wr16, oe16, r16_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (r16_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_rsp got rsp_valid seen=%b required 0", seen);
    end
  endtask

  task automatic test_read16();
    logic [13:0] mq_seq = 14'b01_00_10_01_00_10_11;
    logic [6:0]  rd_seq = 7'b1001001;
    logic [31:0] exp_a;
    exp_t e;
    req_addr = 32'h1002; req_we = 1'b0; req_mask = 4'hF; v16 = 1'b1;
    sb16.push_back('{32'hDEADBEEF, 1'b1, 6});
    @(negedge clk); v16 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (mq16 !== mq_seq[2*(7-c) +: 2] || rd16 !== rd_seq[7-c]) begin
        errors++;
        $display("FAIL read16_strobe c%0d got mreq_n=%b rd_n=%b required %b %b",
                 c, mq16, rd16, mq_seq[2*(7-c) +: 2], rd_seq[7-c]);
      end
      if (c == 1 || c == 4) begin
        exp_a = (c == 1) ? 32'h1000 : 32'h1002;
        checks++;
        if (a16 !== exp_a || mk16 !== 2'b00 || io16 !== 1'b1) begin
          errors++;
          $display("FAIL read16_beat c%0d got addr=%h msk_n=%b iorq_n=%b required %h 00 1",
                   c, a16, mk16, io16, exp_a);
        end
      end
      checks++;
      if (r16_ready !== (c == 7)) begin
        errors++;
        $display("FAIL read16_ready c%0d got %b required %b", c, r16_ready, c == 7);
      end
      if (r16_valid) begin
        checks++;
        if (sb16.size() == 0) begin
          errors++;
          $display("FAIL read16_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sb16.pop_front();
          if (c != e.cyc || (e.is_read && r16_rdata !== e.rdata)) begin
            errors++;
            $display("FAIL read16_rsp got c%0d rdata=%h required c%0d rdata=%h", c, r16_rdata, e.cyc, e.rdata);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb16.size() != 0) begin
      errors++;
      $display("FAIL read16_missing got %0d pending responses required 0", sb16.size());
      sb16.delete();
    end
  endtask

  task automatic test_mask0();
    exp_t e;
    req_addr = 32'h1000; req_we = 1'b0; req_mask = 4'h0; v16 = 1'b1;
    sb16.push_back('{32'h0, 1'b1, 1});
    @(negedge clk); v16 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (mq16 !== 2'b11 || rd16 !== 1'b1 || wr16 !== 2'b11) begin
        errors++;
        $display("FAIL mask0_strobe c%0d got mreq_n=%b rd_n=%b wr_n=%b required 11 1 11", c, mq16, rd16, wr16);
      end
      if (r16_valid) begin
        checks++;
        if (sb16.size() == 0) begin
          errors++;
          $display("FAIL mask0_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sb16.pop_front();
          if (c != e.cyc || r16_rdata !== e.rdata) begin
            errors++;
            $display("FAIL mask0_rsp got c%0d rdata=%h required c%0d rdata=%h", c, r16_rdata, e.cyc, e.rdata);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb16.size() != 0) begin
      errors++;
      $display("FAIL mask0_missing got %0d pending responses required 0", sb16.size());
      sb16.delete();
    end
  endtask

  task automatic test_write16();
    logic [7:0] mq_seq = 8'b01_00_10_11;
    logic [7:0] wr_seq = 8'b11_00_10_11;
    exp_t e;
    req_addr = 32'h2000; req_we = 1'b1; req_mask = 4'b1100; req_wdata = 32'h12345678; v16 = 1'b1;
    sb16.push_back('{32'h0, 1'b0, 3});
    @(negedge clk); v16 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (mq16 !== mq_seq[2*(4-c) +: 2] || wr16 !== wr_seq[2*(4-c) +: 2] || rd16 !== 1'b1) begin
        errors++;
        $display("FAIL write16_strobe c%0d got mreq_n=%b wr_n=%b rd_n=%b required %b %b 1",
                 c, mq16, wr16, rd16, mq_seq[2*(4-c) +: 2], wr_seq[2*(4-c) +: 2]);
      end
      checks++;
      if (oe16 !== (c != 4)) begin
        errors++;
        $display("FAIL write16_oe c%0d got %b required %b", c, oe16, c != 4);
      end
      if (c == 1) begin
        checks++;
        if (a16 !== 32'h2002 || mk16 !== 2'b00 || dout16 !== 16'h1234) begin
          errors++;
          $display("FAIL write16_beat got addr=%h msk_n=%b data_out=%h required 00002002 00 1234",
                   a16, mk16, dout16);
        end
      end
      if (r16_valid) begin
        checks++;
        if (sb16.size() == 0) begin
          errors++;
          $display("FAIL write16_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sb16.pop_front();
          if (c != e.cyc) begin
            errors++;
            $display("FAIL write16_rsp got c%0d required c%0d", c, e.cyc);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb16.size() != 0) begin
      errors++;
      $display("FAIL write16_missing got %0d pending responses required 0", sb16.size());
      sb16.delete();
    end
  endtask

  task automatic test_wait();
    int t2cnt = 0;
    bit raised = 1'b0;
    exp_t e;
    wait_n = 1'b0; dinw = 16'hAAAA;
    req_addr = 32'h3000; req_we = 1'b0; req_mask = 4'b0011; vw = 1'b1;
    sbw.push_back('{32'h00005A5A, 1'b1, 8});
    @(negedge clk); vw = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mqw == 2'b00) t2cnt++;
      if (t2cnt == 6 && !raised) begin
        raised = 1'b1; wait_n = 1'b1; dinw = 16'h5A5A;
      end
      if (rw_valid) begin
        checks++;
        if (sbw.size() == 0) begin
          errors++;
          $display("FAIL wait_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sbw.pop_front();
          if (c != e.cyc || rw_rdata !== e.rdata) begin
            errors++;
            $display("FAIL wait_rsp got c%0d rdata=%h required c%0d rdata=%h", c, rw_rdata, e.cyc, e.rdata);
          end
        end
      end
      @(negedge clk);
    end
    wait_n = 1'b1;
    checks++;
    if (t2cnt != 6) begin
      errors++;
      $display("FAIL wait_t2_len got %0d required 6", t2cnt);
    end
    checks++;
    if (sbw.size() != 0) begin
      errors++;
      $display("FAIL wait_missing got %0d pending responses required 0", sbw.size());
      sbw.delete();
    end
  endtask

  task automatic test_io8();
    logic [31:0] baddr [4];
    int nb = 0;
    exp_t e;
    req_addr = 32'h80000000; req_we = 1'b0; req_mask = 4'b0101; v8 = 1'b1;
    sb8.push_back('{32'h00C200C0, 1'b1, 6});
    @(negedge clk); v8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mq8 == 2'b01) begin
        if (nb < 4) baddr[nb] = a8;
        nb++;
        checks++;
        if (io8 !== 1'b0 || mk8 !== 1'b0) begin
          errors++;
          $display("FAIL io8_beat c%0d got iorq_n=%b msk_n=%b required 0 0", c, io8, mk8);
        end
      end
      if (r8_valid) begin
        checks++;
        if (sb8.size() == 0) begin
          errors++;
          $display("FAIL io8_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sb8.pop_front();
          if (c != e.cyc || r8_rdata !== e.rdata) begin
            errors++;
            $display("FAIL io8_rsp got c%0d rdata=%h required c%0d rdata=%h", c, r8_rdata, e.cyc, e.rdata);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nb != 2 || baddr[0] !== 32'h80000000 || baddr[1] !== 32'h80000002) begin
      errors++;
      $display("FAIL io8_beats got n=%0d a0=%h a1=%h required 2 80000000 80000002", nb, baddr[0], baddr[1]);
    end
    checks++;
    if (sb8.size() != 0) begin
      errors++;
      $display("FAIL io8_missing got %0d pending responses required 0", sb8.size());
      sb8.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    req_addr = 32'h4000; req_we = 1'b0; req_mask = 4'hF; v16 = 1'b1;
    sb16.push_back('{32'h40024000, 1'b1, 6});
    sb16.push_back('{32'h50025000, 1'b1, 13});
    @(negedge clk);
    req_addr = 32'h5000;
    for (int c = 1; c <= 15; c++) begin
      if (c == 7) begin
        checks++;
        if (mq16 !== 2'b11 || r16_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap got mreq_n=%b ready=%b required 11 1", mq16, r16_ready);
        end
      end
      if (c == 8) begin
        v16 = 1'b0;
        checks++;
        if (mq16 !== 2'b01 || a16 !== 32'h5000 || r16_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second got mreq_n=%b addr=%h ready=%b required 01 00005000 0", mq16, a16, r16_ready);
        end
      end
      if (r16_valid) begin
        checks++;
        if (sb16.size() == 0) begin
          errors++;
          $display("FAIL b2b_rsp unexpected rsp_valid at c%0d", c);
        end else begin
          e = sb16.pop_front();
          if (c != e.cyc || r16_rdata !== e.rdata) begin
            errors++;
            $display("FAIL b2b_rsp got c%0d rdata=%h required c%0d rdata=%h", c, r16_rdata, e.cyc, e.rdata);
          end
        end
      end
      @(negedge clk);
    end
    v16 = 1'b0;
    checks++;
    if (sb16.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing got %0d pending responses required 0", sb16.size());
      sb16.delete();
    end
  endtask

  initial begin
    test_reset();
    test_read16();
    test_mask0();
    test_write16();
    test_wait();
    test_io8();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
